// File: rtl/crisp_pkg.sv
// Shared register-file constants for the integer core: address width,
// XLEN, the hard-wired zero register and requester indices.
package crisp_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MUL = 2;
endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or after ptr,
// wrapping modulo N, reported as one-hot grant plus binary index.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             found,
    output logic [PTR_W-1:0] idx
);
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // Walk the search order backwards so the earliest candidate is written last.
        for (int off = N - 1; off >= 0; off--) begin
            int j;
            j = (int'(ptr) + off) % N;
            if (valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                found    = 1'b1;
                idx      = PTR_W'(j);
            end
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin grant of one producer per cycle onto the
// register file's single write port through a one-entry output register.
module rf_wb_arbiter
    import crisp_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         hold,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rf_write_en,
    output logic [REG_ADDR_W-1:0]        rf_rd_select,
    output logic [DATA_W-1:0]            rf_data_in,
    output logic [CNT_W-1:0]             conflict_cnt
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_p0;
    logic [NUM_REQ-1:0] vld_mask_p0;
    logic [NUM_REQ-1:0] grant_p0;
    logic               found_p0;
    logic [PTR_W-1:0]   win_p0;
    logic [PTR_W-1:0]   ptr_nxt_p0;
    reg_addr_t          win_rd_p0;
    logic [DATA_W-1:0]  win_data_p0;
    logic               conflict_p0;

    logic               vld_p1;
    reg_addr_t          rd_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [CNT_W-1:0]   cnt_p1;

    // Stage 0: combinational arbitration; reset and freeze mask every request.
    assign vld_mask_p0 = (rst || hold) ? '0 : req_valid;

    rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .valid (vld_mask_p0),
        .ptr   (ptr_p0),
        .grant (grant_p0),
        .found (found_p0),
        .idx   (win_p0)
    );

    assign req_ready   = grant_p0;
    assign win_rd_p0   = req_rd[int'(win_p0)*REG_ADDR_W +: REG_ADDR_W];
    assign win_data_p0 = req_data[int'(win_p0)*DATA_W +: DATA_W];
    assign ptr_nxt_p0  = (int'(win_p0) == NUM_REQ - 1) ? '0 : win_p0 + PTR_W'(1);
    assign conflict_p0 = !hold && ($countones(req_valid) >= 2);

    // Stage 1: output register feeding the register-file write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_p0  <= '0;
            vld_p1  <= 1'b0;
            rd_p1   <= '0;
            data_p1 <= '0;
            cnt_p1  <= '0;
        end else begin
            // x0 grants release the requester but never reach the file.
            vld_p1 <= found_p0 && (win_rd_p0 != REG_ZERO);
            if (found_p0) begin
                ptr_p0  <= ptr_nxt_p0;
                rd_p1   <= win_rd_p0;
                data_p1 <= win_data_p0;
            end
            if (conflict_p0 && (cnt_p1 != {CNT_W{1'b1}}))
                cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
    end

    assign rf_write_en  = vld_p1;
    assign rf_rd_select = rd_p1;
    assign rf_data_in   = data_p1;
    assign conflict_cnt = cnt_p1;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: table of arbitration vectors plus
// hand-written reset, hold and counter-saturation sequences.
module tb_rf_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        hold;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;

    logic [2:0]  req_ready,   req_ready_s;
    logic        rf_write_en, rf_write_en_s;
    logic [4:0]  rf_rd_select, rf_rd_select_s;
    logic [31:0] rf_data_in,  rf_data_in_s;
    logic [15:0] conflict_cnt;
    logic [3:0]  conflict_cnt_s;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
        .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
        .rf_write_en(rf_write_en), .rf_rd_select(rf_rd_select),
        .rf_data_in(rf_data_in), .conflict_cnt(conflict_cnt)
    );

    rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid),
        .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready_s),
        .rf_write_en(rf_write_en_s), .rf_rd_select(rf_rd_select_s),
        .rf_data_in(rf_data_in_s), .conflict_cnt(conflict_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic [2:0]  valid;
        logic [4:0]  rd1;
        logic [31:0] d1;
        logic [2:0]  ready;
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic h, logic [2:0] v, logic [2:0] r,
                                logic w, logic [4:0] rd, logic [31:0] d);
        vec_t x;
        x.hold = h; x.valid = v; x.rd1 = 5'd2; x.d1 = 32'hB;
        x.ready = r; x.wen = w; x.rd = rd; x.data = d;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] rd0, input logic [31:0] d0,
                           input logic [4:0] rd1, input logic [31:0] d1);
        req_rd   = {5'd3, rd1, rd0};
        req_data = {32'hC, d1, d0};
    endtask

    int exp_cnt;

    initial begin
        // Round-robin over three writers, then x0 drop, hold, resume, single writer.
        for (int i = 0; i < 2; i++) begin
            tbl[3*i+0] = mk(0, 3'b111, 3'b001, 1, 5'd1, 32'hA);
            tbl[3*i+1] = mk(0, 3'b111, 3'b010, 1, 5'd2, 32'hB);
            tbl[3*i+2] = mk(0, 3'b111, 3'b100, 1, 5'd3, 32'hC);
        end
        tbl[6] = mk(0, 3'b010, 3'b010, 0, 5'd0, 32'h0);
        tbl[6].rd1 = 5'd0; tbl[6].d1 = 32'hDEADBEEF;
        tbl[7]  = mk(1, 3'b111, 3'b000, 0, 5'd0, 32'h0);
        tbl[8]  = mk(1, 3'b111, 3'b000, 0, 5'd0, 32'h0);
        tbl[9]  = mk(1, 3'b111, 3'b000, 0, 5'd0, 32'h0);
        tbl[10] = mk(0, 3'b111, 3'b100, 1, 5'd3, 32'hC);
        tbl[11] = mk(0, 3'b111, 3'b001, 1, 5'd1, 32'hA);
        tbl[12] = mk(0, 3'b001, 3'b001, 1, 5'd1, 32'hA);
        tbl[13] = mk(0, 3'b001, 3'b001, 1, 5'd1, 32'hA);
        tbl[14] = mk(0, 3'b000, 3'b000, 0, 5'd0, 32'h0);
        tbl[15] = mk(0, 3'b110, 3'b010, 1, 5'd2, 32'hB);
        tbl[16] = mk(0, 3'b110, 3'b100, 1, 5'd3, 32'hC);
        tbl[17] = mk(0, 3'b110, 3'b010, 1, 5'd2, 32'hB);

        // Reset with every requester asserting.
        rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
        set_req(5'd1, 32'hA, 5'd2, 32'hB);
        #1;
        chk("rst_ready", 64'(req_ready), 64'(3'b000));
        tick();
        chk("rst_ready_2", 64'(req_ready), 64'(3'b000));
        tick();
        chk("rst_wen", 64'(rf_write_en), 64'(1'b0));
        chk("rst_rd", 64'(rf_rd_select), 64'(5'd0));
        chk("rst_data", 64'(rf_data_in), 64'(32'h0));
        chk("rst_cnt", 64'(conflict_cnt), 64'(16'd0));
        chk("rst_cnt_s", 64'(conflict_cnt_s), 64'(4'd0));
        rst = 1'b0;

        exp_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            hold = tbl[i].hold;
            req_valid = tbl[i].valid;
            set_req(5'd1, 32'hA, tbl[i].rd1, tbl[i].d1);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(tbl[i].ready));
            if (!tbl[i].hold && ($countones(tbl[i].valid) >= 2)) exp_cnt++;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wen", i), 64'(rf_write_en), 64'(tbl[i].wen));
            if (tbl[i].wen) begin
                chk($sformatf("v%0d_rd", i), 64'(rf_rd_select), 64'(tbl[i].rd));
                chk($sformatf("v%0d_data", i), 64'(rf_data_in), 64'(tbl[i].data));
            end
            chk($sformatf("v%0d_cnt", i), 64'(conflict_cnt), 64'(exp_cnt));
        end

        // Transfer attempted in the reset cycle is discarded.
        hold = 1'b0; req_valid = 3'b001; rst = 1'b1;
        set_req(5'd5, 32'h1234, 5'd2, 32'hB);
        #1;
        chk("midrst_ready", 64'(req_ready), 64'(3'b000));
        tick();
        chk("midrst_wen", 64'(rf_write_en), 64'(1'b0));
        chk("midrst_rd", 64'(rf_rd_select), 64'(5'd0));
        chk("midrst_data", 64'(rf_data_in), 64'(32'h0));
        chk("midrst_cnt", 64'(conflict_cnt), 64'(16'd0));
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'(3'b001));
        @(posedge clk);
        #1;
        chk("post_rst_wen", 64'(rf_write_en), 64'(1'b1));
        chk("post_rst_rd", 64'(rf_rd_select), 64'(5'd5));
        chk("post_rst_data", 64'(rf_data_in), 64'(32'h1234));

        // Hold rising with a write pending: the write stays visible this cycle.
        hold = 1'b1;
        #1;
        chk("hold_pend_wen", 64'(rf_write_en), 64'(1'b1));
        chk("hold_pend_ready", 64'(req_ready), 64'(3'b000));
        @(posedge clk);
        #1;
        chk("hold_wen_off", 64'(rf_write_en), 64'(1'b0));
        hold = 1'b0;
        #1;
        chk("hold_resume_ready", 64'(req_ready), 64'(3'b001));

        // Counter saturation: two writers for 20 cycles.
        rst = 1'b1; req_valid = 3'b011;
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 15 || c == 16)
                chk($sformatf("sat_c%0d", c), 64'(conflict_cnt_s), 64'(4'd15));
        end
        chk("sat_final_s", 64'(conflict_cnt_s), 64'(4'd15));
        chk("sat_final_wide", 64'(conflict_cnt), 64'(16'd20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the single write port of the 32×32 integer register file. Collects write requests from NUM_REQ producers (ALU, load unit, multi-cycle unit) over valid/ready handshakes. Grants one per cycle by round-robin and drives the register file's write port from a one-entry output register. Sits between the execute/memory stages and the register file; the file's combinational rd==rs bypass covers the one-cycle write latency.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters; legal 2..8; index 0 = ALU
- DATA_W, 32, write data width
- CNT_W, 16, width of the saturating conflict counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  pipeline freeze; no grants while high
- req_valid  in  NUM_REQ  per-requester write request
- req_rd  in  NUM_REQ×5  destination register per requester
- req_data  in  NUM_REQ×DATA_W  write data per requester
- req_ready  out  NUM_REQ  one-hot or zero grant; transfer = valid & ready
- rf_write_en  out  1  to register file write enable
- rf_rd_select  out  5  to register file destination select
- rf_data_in  out  DATA_W  to register file write data
- conflict_cnt  out  CNT_W  saturating count of cycles with ≥2 valid requests and hold low

## Operation
- State: round-robin pointer `ptr` (log2 NUM_REQ bits), output register {wr_en, rd, data}, conflict_cnt.
- Arbitration is combinational each cycle. Search starts at `ptr` and wraps modulo NUM_REQ; the first i with req_valid[i] wins. req_ready[winner]=1 and all others 0.
- hold=1: req_ready all 0, ptr unchanged, conflict_cnt unchanged. The output register still loads wr_en=0 (no write during freeze).
- On a transfer from requester w: ptr ← (w+1) mod NUM_REQ. The output register loads {1, req_rd[w], req_data[w]}.
- No transfer: output register loads wr_en=0. rd and data hold their previous values.
- x0 writes: granted normally (requester is released and ptr advances), but the output register loads wr_en=0. rf_write_en is never asserted with rf_rd_select=0.
- req_ready does not depend on downstream backpressure; the register file always accepts.
- Requesters must hold req_valid, req_rd and req_data stable until the transfer. The arbiter does not drop or reorder requests from one requester.
- conflict_cnt increments by 1 when hold=0 and popcount(req_valid)≥2. It saturates at 2^CNT_W−1 and does not wrap.
- Reset values: ptr=0, rf_write_en=0, rf_rd_select=0, rf_data_in=0, conflict_cnt=0. req_ready is combinational and evaluates to 0 while rst=1.

## Timing
- Latency: a transfer at edge T (sampled valid&ready) produces rf_write_en=1 during cycle T→T+1. The register file commits it at edge T+1.
- Throughput: one write per cycle.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles of hold-low time.
- Single requester valid: granted every cycle, with no bubble.
- Simultaneous reset and request: reset wins. No transfer, req_ready=0, and the pending output-register write is discarded (rf_write_en=0 next cycle).
- hold rising while an output write is pending: that write still completes. Only new grants are blocked.

## Structure
- Shared package `crisp_pkg`: REG_ADDR_W=5, XLEN=32, REG_ZERO=5'd0, and the requester index constants REQ_ALU=0, REQ_LSU=1, REQ_MUL=2.
- One sub-module: `rr_pick`. It is a purely combinational round-robin priority picker that takes (valid vector, ptr) and returns (one-hot grant, found, index). The arbiter instantiates it once.
- The conflict counter and output register stay inline.

## Test plan
- Reset: assert rst for 2 cycles with all req_valid=1 → req_ready=0, rf_write_en=0, conflict_cnt=0. The first grant after release goes to req 0.
- Round-robin: all three requesters valid continuously, writing rd=1,2,3 with data 0xA,0xB,0xC. Expected: rf_write_en each cycle, rd sequence 1,2,3,1,2,3, and conflict_cnt increments every cycle.
- x0 drop: only req 1 valid with rd=0, data=0xDEADBEEF → req_ready[1]=1 and next cycle rf_write_en=0. A register-file read of x0 returns 0.
- Hold: all valid, hold=1 for 3 cycles → no ready and no writes, ptr frozen, conflict_cnt unchanged. Once hold drops, the grant resumes at the frozen ptr.
- Reset mid-operation: transfer rd=5, data=0x1234 at edge T, with rst=1 in the same cycle → no write of x5, and all outputs at reset values.
- Saturation: with CNT_W=4, hold two requesters valid for 20 cycles → conflict_cnt stops at 15.
